// File: rtl/cei_mochila_pkg.sv
// Shared constants and types for the CB_CTRL responder.
// Optional error responses are enabled by defining CB_CTRL_ERR_RESP_EN.
package cei_mochila_pkg;

  localparam logic [31:0] CB_CTRL_START_ADDRESS = 32'hF0011000;
  localparam logic [31:0] CB_CTRL_SIZE = 32'h00001000;
  localparam int unsigned CB_CTRL_IDX = 1;

  localparam logic [11:0] CB_CTRL_CTRL_OFFSET = 12'h000;
  localparam logic [11:0] CB_CTRL_STATUS_OFFSET = 12'h004;
  localparam logic [11:0] CB_CTRL_BOOT_ADDR0_OFFSET = 12'h008;
  localparam logic [11:0] CB_CTRL_BOOT_ADDR1_OFFSET = 12'h00C;
  localparam logic [11:0] CB_CTRL_SCRATCH_OFFSET = 12'h010;
  localparam logic [11:0] CB_CTRL_EVENT_OFFSET = 12'h014;

  typedef enum logic [1:0] {
    BOOT_IDLE,
    BOOT_WAIT,
    BOOT_RUN
  } boot_state_t;

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = be_mask(be);
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/cb_ctrl_boot_seq.sv
// Single-core boot sequencer: delays fetch enable after core enable.
// en_i is the next-cycle core enable so fetch lags core_en by BOOT_DELAY.
module cb_ctrl_boot_seq
  import cei_mochila_pkg::*;
#(
  parameter int unsigned BOOT_DELAY = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic fetch_en_o
);

  localparam logic [7:0] LOAD = 8'(BOOT_DELAY - 1);

  boot_state_t state;
  logic [7:0]  cnt;
  logic        en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= BOOT_IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= en_i;
      if (!en_i) begin
        state <= BOOT_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          BOOT_IDLE: begin
            if (!en_q) begin
              state <= BOOT_WAIT;
              cnt   <= LOAD;
            end
          end
          BOOT_WAIT: begin
            if (cnt == 8'd0) state <= BOOT_RUN;
            else             cnt   <= cnt - 8'd1;
          end
          BOOT_RUN: state <= BOOT_RUN;
          default:  state <= BOOT_IDLE;
        endcase
      end
    end
  end

  assign fetch_en_o = (state == BOOT_RUN);

endmodule

// File: rtl/cb_ctrl_obi_responder.sv
// OBI responder for the CB_CTRL window: core control/status registers.
// Define CB_CTRL_ERR_RESP_EN to flag unmapped and STATUS-write accesses.
module cb_ctrl_obi_responder
  import cei_mochila_pkg::*;
#(
  parameter int unsigned BOOT_DELAY    = 16,
  parameter logic [31:0] BOOT_ADDR_RST = 32'hF0010000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic [1:0]  core_sleep_i,
  input  logic [1:0]  event_i,
  output logic [1:0]  core_en_o,
  output logic [1:0]  fetch_en_o,
  output logic [31:0] boot_addr0_o,
  output logic [31:0] boot_addr1_o,
  output logic        intr_o
);

  logic [11:0] off;
  logic        sel_ctrl, sel_status, sel_boot0;
  logic        sel_boot1, sel_scratch, sel_event;
  logic        sel_map, acc_err, wr;
  logic        unused_addr;

  logic [3:0]  ctrl_q, ctrl_nxt;
  logic [31:0] boot0_q, boot0_nxt;
  logic [31:0] boot1_q, boot1_nxt;
  logic [31:0] scratch_q, scratch_nxt;
  logic [1:0]  ev_q, ev_nxt, ev_clr;
  logic [31:0] ctrl_w, rd_val;

  assign gnt_o = req_i;
  assign off   = {addr_i[11:2], 2'b00};
  assign unused_addr = ^{addr_i[31:12], addr_i[1:0]};

  assign sel_ctrl    = (off == CB_CTRL_CTRL_OFFSET);
  assign sel_status  = (off == CB_CTRL_STATUS_OFFSET);
  assign sel_boot0   = (off == CB_CTRL_BOOT_ADDR0_OFFSET);
  assign sel_boot1   = (off == CB_CTRL_BOOT_ADDR1_OFFSET);
  assign sel_scratch = (off == CB_CTRL_SCRATCH_OFFSET);
  assign sel_event   = (off == CB_CTRL_EVENT_OFFSET);
  assign sel_map = sel_ctrl | sel_status | sel_boot0
                 | sel_boot1 | sel_scratch | sel_event;

`ifdef CB_CTRL_ERR_RESP_EN
  assign acc_err = req_i & (~sel_map | (we_i & sel_status));
`else
  assign acc_err = 1'b0;
`endif

  assign wr = req_i & we_i & ~acc_err;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ctrl:    rd_val = {28'd0, ctrl_q};
      sel_status:  rd_val = {28'd0, fetch_en_o, core_sleep_i};
      sel_boot0:   rd_val = boot0_q;
      sel_boot1:   rd_val = boot1_q;
      sel_scratch: rd_val = scratch_q;
      sel_event:   rd_val = {30'd0, ev_q};
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    ctrl_w   = be_merge({28'd0, ctrl_q}, wdata_i, be_i);
    ctrl_nxt = (wr && sel_ctrl) ? ctrl_w[3:0] : ctrl_q;
    boot0_nxt = (wr && sel_boot0)
              ? be_merge(boot0_q, wdata_i, be_i) : boot0_q;
    boot1_nxt = (wr && sel_boot1)
              ? be_merge(boot1_q, wdata_i, be_i) : boot1_q;
    scratch_nxt = (wr && sel_scratch)
                ? be_merge(scratch_q, wdata_i, be_i) : scratch_q;
    ev_clr = (wr && sel_event)
           ? (wdata_i[1:0] & {2{be_i[0]}}) : 2'b00;
    // A new event in the same cycle as its clear keeps the flag set
    ev_nxt = (ev_q & ~ev_clr) | event_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      boot0_q   <= BOOT_ADDR_RST;
      boot1_q   <= BOOT_ADDR_RST;
      scratch_q <= '0;
      ev_q      <= '0;
      intr_o    <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_nxt;
      boot0_q   <= boot0_nxt;
      boot1_q   <= boot1_nxt;
      scratch_q <= scratch_nxt;
      ev_q      <= ev_nxt;
      intr_o    <= |(ev_nxt & ctrl_nxt[3:2]);
      rvalid_o  <= req_i;
      rdata_o   <= (req_i && !we_i && !acc_err) ? rd_val : '0;
      err_o     <= acc_err;
    end
  end

  assign core_en_o    = ctrl_q[1:0];
  assign boot_addr0_o = boot0_q;
  assign boot_addr1_o = boot1_q;

  for (genvar n = 0; n < 2; n++) begin : g_seq
    cb_ctrl_boot_seq #(
      .BOOT_DELAY(BOOT_DELAY)
    ) u_seq (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (ctrl_nxt[n]),
      .fetch_en_o (fetch_en_o[n])
    );
  end

endmodule

// File: tb/tb_cb_ctrl_obi_responder.sv
// Scoreboard bench for cb_ctrl_obi_responder with a behavioural model.
// Model follows CB_CTRL_ERR_RESP_EN the same way as the design.
module tb_cb_ctrl_obi_responder;

  localparam int D = 16;
  localparam logic [31:0] RST = 32'hF0010000;
`ifdef CB_CTRL_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk, rst_ni;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, intr_o;
  logic [31:0] rdata_o, boot_addr0_o, boot_addr1_o;
  logic [1:0]  core_sleep_i, event_i, core_en_o, fetch_en_o;

  cb_ctrl_obi_responder #(
    .BOOT_DELAY(D),
    .BOOT_ADDR_RST(RST)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .core_sleep_i (core_sleep_i),
    .event_i      (event_i),
    .core_en_o    (core_en_o),
    .fetch_en_o   (fetch_en_o),
    .boot_addr0_o (boot_addr0_o),
    .boot_addr1_o (boot_addr1_o),
    .intr_o       (intr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  en;
    logic [1:0]  fe;
    logic        intr;
    logic [31:0] b0;
    logic [31:0] b1;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [1:0]  m_en, m_mask, m_ev;
  logic [31:0] m_b0, m_b1, m_scr;
  int          m_age[2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic m_fe(input int n);
    return m_en[n] && (m_age[n] >= D);
  endfunction

  task automatic m_reset();
    m_en = 0; m_mask = 0; m_ev = 0;
    m_b0 = RST; m_b1 = RST; m_scr = 0;
    m_age[0] = 0; m_age[1] = 0;
  endtask

  function automatic exp_t snap(input logic v,
                                input logic [31:0] rd,
                                input logic e);
    exp_t x;
    x.v = v; x.rdata = rd; x.err = e;
    x.en = m_en;
    x.fe = {m_fe(1), m_fe(0)};
    x.intr = |(m_ev & m_mask);
    x.b0 = m_b0; x.b1 = m_b1;
    return x;
  endfunction

  // One bus cycle: drive, predict response and post-edge state, push.
  task automatic step(input logic rq, input logic w,
                      input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] ev);
    int          off;
    logic        mapped, e;
    logic [31:0] rd, t;
    logic [1:0]  clr, new_en;
    req_i = rq; we_i = w; be_i = b;
    addr_i = a; wdata_i = wd; event_i = ev;
    core_sleep_i = 2'($urandom);
    off = int'(a[11:2]);
    mapped = off < 6;
    e = ERR && rq && (!mapped || (w && off == 1));
    case (off)
      0: rd = {28'd0, m_mask, m_en};
      1: rd = {28'd0, m_fe(1), m_fe(0), core_sleep_i};
      2: rd = m_b0;
      3: rd = m_b1;
      4: rd = m_scr;
      5: rd = {30'd0, m_ev};
      default: rd = 0;
    endcase
    clr = 0;
    new_en = m_en;
    if (rq && w && !e) begin
      case (off)
        0: begin
          t = merge({28'd0, m_mask, m_en}, wd, b);
          new_en = t[1:0];
          m_mask = t[3:2];
        end
        2: m_b0 = merge(m_b0, wd, b);
        3: m_b1 = merge(m_b1, wd, b);
        4: m_scr = merge(m_scr, wd, b);
        5: clr = b[0] ? wd[1:0] : 2'b00;
        default: ;
      endcase
    end
    for (int n = 0; n < 2; n++) begin
      if (new_en[n] && !m_en[n]) m_age[n] = 0;
      else if (new_en[n] && m_age[n] < 1000) m_age[n]++;
    end
    m_en = new_en;
    m_ev = (m_ev & ~clr) | ev;
    q.push_back(snap(rq, (rq && !w && !e) ? rd : 32'd0, e));
    #1 chk("gnt", 32'(gnt_o), 32'(rq));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1, 0, 4'hF, a, $urandom, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    step(1, 1, b, a, d, 0);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("rvalid", 32'(rvalid_o), 32'(x.v));
      if (x.v) begin
        chk("rdata", rdata_o, x.rdata);
        chk("err", 32'(err_o), 32'(x.err));
      end
      chk("core_en", 32'(core_en_o), 32'(x.en));
      chk("fetch_en", 32'(fetch_en_o), 32'(x.fe));
      chk("intr", 32'(intr_o), 32'(x.intr));
      chk("boot0", boot_addr0_o, x.b0);
      chk("boot1", boot_addr1_o, x.b1);
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rvalid"}, 32'(rvalid_o), 0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_core_en"}, 32'(core_en_o), 0);
    chk({tag, "_fetch_en"}, 32'(fetch_en_o), 0);
    chk({tag, "_intr"}, 32'(intr_o), 0);
    chk({tag, "_boot0"}, boot_addr0_o, RST);
    chk({tag, "_boot1"}, boot_addr1_o, RST);
  endtask

  initial begin
    logic [31:0] r, a;
    logic [11:0] offs[10];
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
             12'h014, 12'h018, 12'h01C, 12'h040, 12'hFFC};
    rst_ni = 0; req_i = 0; we_i = 0; be_i = 0;
    addr_i = 0; wdata_i = 0; event_i = 0; core_sleep_i = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    req_i = 1;
    #1 chk("rst_gnt", 32'(gnt_o), 1);
    req_i = 0;
    @(negedge clk);
    rst_ni = 1;

    rd(32'hF0011008);
    idle(1);
    wr(32'hF0011010, 32'h11223344, 4'hF);
    wr(32'hF0011010, 32'hAABBCCDD, 4'b0101);
    rd(32'hF0011010);

    wr(32'hF0011000, 32'h1, 4'hF);
    idle(20);
    rd(32'hF0011004);
    wr(32'hF0011000, 32'h0, 4'hF);
    wr(32'hF0011000, 32'h1, 4'hF);
    idle(5);
    wr(32'hF0011000, 32'h0, 4'hF);
    idle(20);

    wr(32'hF0011000, 32'h8, 4'hF);
    step(1, 1, 4'hF, 32'hF0011014, 32'h2, 2'b10);
    idle(2);
    rd(32'hF0011014);
    wr(32'hF0011014, 32'h2, 4'hF);
    idle(2);

    rd(32'hF0011040);
    wr(32'hF0011040, 32'hFFFFFFFF, 4'hF);
    wr(32'hF0011004, 32'hFFFFFFFF, 4'hF);
    rd(32'hF0011004);
    wr(32'hF001100C, 32'h12345678, 4'b1010);
    rd(32'hF001100C);

    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      a = {r[31:12], offs[$urandom_range(0, 9)]};
      step($urandom_range(0, 3) != 0, r[0], 4'($urandom), a,
           (a[11:0] == 12'h000) ? {28'd0, 4'($urandom)} : $urandom,
           ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
      if ($urandom_range(0, 49) == 0) idle(D + 2);
    end

    rd(32'hF0011000);
    rd(32'hF0011008);
    rd(32'hF0011010);
    req_i = 1; we_i = 0; be_i = 4'hF; addr_i = 32'hF001100C;
    #1 rst_ni = 0;
    m_reset();
    q.push_back(snap(0, 0, 0));
    @(posedge clk);
    #2 chk_reset_outs("midrst");
    @(negedge clk);
    req_i = 0;
    rst_ni = 1;
    idle(3);

    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
